// File: rtl/ex_wb_if.sv
// ----------------------------------------------------------------------------
// ex_wb_if : signal bundle between the EX stage / data memory and the
//            EX->WB pipeline stage.
//
// master modport (EX side / pipeline control):
//   drives  stall_i, flush_i, valid_i, alu_result_i, pc_plus_i, rd_addr_i,
//           control_wb_i, control_wr_mux_i, control_load_i, control_csr_we_i,
//           csr_data_i, dmem_dout_i
//   reads   wb_data_o, wb_addr_o, is_wb_o, csr_tohost_o, instret_o
// slave modport (the ex_wb stage): the mirror image.
// ----------------------------------------------------------------------------
interface ex_wb_if;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_plus_i;
    logic [4:0]  rd_addr_i;
    logic        control_wb_i;
    logic [1:0]  control_wr_mux_i;
    logic [2:0]  control_load_i;
    logic        control_csr_we_i;
    logic [31:0] csr_data_i;
    logic [31:0] dmem_dout_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_addr_o;
    logic        is_wb_o;
    logic [31:0] csr_tohost_o;
    logic [31:0] instret_o;

    modport master (
        output stall_i, flush_i, valid_i, alu_result_i, pc_plus_i, rd_addr_i,
               control_wb_i, control_wr_mux_i, control_load_i,
               control_csr_we_i, csr_data_i, dmem_dout_i,
        input  wb_data_o, wb_addr_o, is_wb_o, csr_tohost_o, instret_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, alu_result_i, pc_plus_i, rd_addr_i,
               control_wb_i, control_wr_mux_i, control_load_i,
               control_csr_we_i, csr_data_i, dmem_dout_i,
        output wb_data_o, wb_addr_o, is_wb_o, csr_tohost_o, instret_o
    );
endinterface

// File: rtl/ex_wb.sv
// ----------------------------------------------------------------------------
// ex_wb : EX->WB pipeline register with writeback mux, load data extraction,
//         load-hold logic for stalls, tohost CSR and retired-instruction count.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - ex_wb_if.slave: stall/flush, EX instruction fields, DMEM read
//          word in; writeback data/address/enable, tohost and instret out.
//
// Loads: the DMEM word arrives the cycle the load sits in this stage and is
// consumed combinationally. If the stage stalls, the DMEM output may move on,
// so the word is captured on the first stalled edge and used from then on.
// ----------------------------------------------------------------------------
module ex_wb (
    input  logic    clk,
    input  logic    rst,
    ex_wb_if.slave  bus
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_CSR  = 2'b11;

    typedef enum logic {LIVE, HELD} hold_state_e;

    // stage contents
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] pc_plus;
    logic [4:0]  rd_addr;
    logic        ctl_wb;
    logic [1:0]  wr_mux;
    logic [2:0]  load_f3;
    logic        csr_we;
    logic [31:0] csr_data;

    hold_state_e state, state_next;
    logic [31:0] hold_word;
    logic [31:0] csr_tohost;
    logic [31:0] instret;

    logic        advance;
    logic        retire;
    logic        start_hold;
    logic [1:0]  byte_off;
    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    // flush beats stall: a flushed edge never advances and never retires
    assign advance    = !bus.stall_i && !bus.flush_i;
    assign retire     = valid && advance;
    assign start_hold = (state == LIVE) && bus.stall_i && !bus.flush_i &&
                        valid && (wr_mux == WB_LOAD);
    assign byte_off   = alu_result[1:0];

    // NOTE: every sequential block uses non-blocking (<=) so all registers
    // update from pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= 1'b0;
            alu_result <= '0;
            pc_plus    <= '0;
            rd_addr    <= '0;
            ctl_wb     <= 1'b0;
            wr_mux     <= WB_ALU;
            load_f3    <= '0;
            csr_we     <= 1'b0;
            csr_data   <= '0;
        end else if (bus.flush_i) begin
            // only the valid bit matters for a bubble; payload is left as is
            valid <= 1'b0;
        end else if (!bus.stall_i) begin
            valid      <= bus.valid_i;
            alu_result <= bus.alu_result_i;
            pc_plus    <= bus.pc_plus_i;
            rd_addr    <= bus.rd_addr_i;
            ctl_wb     <= bus.control_wb_i;
            wr_mux     <= bus.control_wr_mux_i;
            load_f3    <= bus.control_load_i;
            csr_we     <= bus.control_csr_we_i;
            csr_data   <= bus.csr_data_i;
        end
    end

    // load-hold FSM: state register and hold word
    // NOTE: hold_word is reset too, so a reset mid-stall leaves no stale load
    // data behind; its contents are only ever read in HELD anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LIVE;
            hold_word <= '0;
        end else begin
            state <= state_next;
            if (start_hold) begin
                hold_word <= bus.dmem_dout_i;
            end
        end
    end

    // NOTE: next-state defaults to the current state before the case, so no
    // path leaves state_next unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            LIVE:    if (start_hold) state_next = HELD;
            HELD:    if (!bus.stall_i || bus.flush_i) state_next = LIVE;
            default: state_next = LIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_tohost <= '0;
            instret    <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
            if (csr_we) begin
                csr_tohost <= csr_data;
            end
        end
    end

    // load data extraction
    always_comb begin
        load_word = (state == HELD) ? hold_word : bus.dmem_dout_i;
        case (byte_off)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = byte_off[1] ? load_word[31:16] : load_word[15:0];
        case (load_f3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        case (wr_mux)
            WB_ALU:  wb_data = alu_result;
            WB_LOAD: wb_data = load_data;
            WB_PC:   wb_data = pc_plus;
            WB_CSR:  wb_data = csr_data;
            default: wb_data = alu_result;
        endcase
    end

    assign bus.wb_data_o    = wb_data;
    assign bus.wb_addr_o    = rd_addr;
    assign bus.is_wb_o      = valid && ctl_wb && (rd_addr != 5'd0);
    assign bus.csr_tohost_o = csr_tohost;
    assign bus.instret_o    = instret;

endmodule

// File: tb/tb_ex_wb.sv
// ----------------------------------------------------------------------------
// tb_ex_wb : self-checking bench for ex_wb. A behavioural model tracks what
// instruction sits in the stage, which DMEM word a stalled load must keep
// seeing, and the tohost / instret values, and predicts every output.
// ----------------------------------------------------------------------------
module tb_ex_wb;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wb;
        logic [1:0]  mux;
        logic [2:0]  f3;
        logic        csr_we;
        logic [31:0] csr;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_wb_if bus ();

    ex_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // reference model
    logic        m_valid = 1'b0;
    ex_t         m_ex    = '0;
    logic        m_held  = 1'b0;
    logic [31:0] m_hold  = '0;
    logic [31:0] m_tohost = '0;
    logic [31:0] m_instret = '0;

    function automatic ex_t mk_ex(input logic v, input logic [31:0] alu,
                                  input logic [31:0] pc, input logic [4:0] rd,
                                  input logic wb, input logic [1:0] mux,
                                  input logic [2:0] f3, input logic csr_we,
                                  input logic [31:0] csr);
        ex_t e;
        e.valid = v; e.alu = alu; e.pc = pc; e.rd = rd; e.wb = wb;
        e.mux = mux; e.f3 = f3; e.csr_we = csr_we; e.csr = csr;
        return e;
    endfunction

    function automatic ex_t rand_ex();
        ex_t e;
        e.valid  = ($urandom_range(0, 3) != 0);
        e.alu    = $urandom;
        e.pc     = $urandom;
        e.rd     = 5'($urandom_range(0, 31));
        e.wb     = 1'($urandom_range(0, 1));
        e.mux    = 2'($urandom_range(0, 3));
        e.f3     = 3'($urandom_range(0, 7));
        e.csr_we = 1'($urandom_range(0, 1));
        e.csr    = $urandom;
        return e;
    endfunction

    // Load value from arithmetic on the word: shift, mask, and subtract the
    // field range when the top bit of the field is set.
    function automatic logic [31:0] exp_load(input logic [31:0] w,
                                             input int off, input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_wb_data();
        logic [31:0] w;
        w = m_held ? m_hold : bus.dmem_dout_i;
        case (m_ex.mux)
            2'b00:   return m_ex.alu;
            2'b01:   return exp_load(w, int'(m_ex.alu % 4), m_ex.f3);
            2'b10:   return m_ex.pc;
            default: return m_ex.csr;
        endcase
    endfunction

    function automatic logic exp_is_wb();
        return m_valid && m_ex.wb && (m_ex.rd != 5'd0);
    endfunction

    // What one clock edge does, in terms of instructions moving and retiring.
    function automatic void model_edge(input ex_t ex, input logic st,
                                       input logic fl, input logic r,
                                       input logic [31:0] dout);
        if (r) begin
            m_valid = 1'b0; m_ex = '0; m_held = 1'b0; m_hold = '0;
            m_tohost = '0; m_instret = '0;
            return;
        end
        if (m_valid && !st && !fl) begin
            m_instret = m_instret + 32'd1;
            if (m_ex.csr_we) m_tohost = m_ex.csr;
        end
        // a stalled load keeps the word that was on DMEM at its first stalled edge
        if (fl || !st) m_held = 1'b0;
        else if (m_valid && m_ex.mux == 2'b01 && !m_held) begin
            m_held = 1'b1;
            m_hold = dout;
        end
        if (fl) m_valid = 1'b0;
        else if (!st) begin
            m_valid = ex.valid;
            m_ex    = ex;
        end
    endfunction

    // Apply one edge's inputs, advance the model, then present the DMEM word
    // for the following cycle. Returns 2 time units after the edge.
    task automatic step(input ex_t ex, input logic st, input logic fl,
                        input logic r, input logic [31:0] dout_after);
        bus.valid_i          = ex.valid;
        bus.alu_result_i     = ex.alu;
        bus.pc_plus_i        = ex.pc;
        bus.rd_addr_i        = ex.rd;
        bus.control_wb_i     = ex.wb;
        bus.control_wr_mux_i = ex.mux;
        bus.control_load_i   = ex.f3;
        bus.control_csr_we_i = ex.csr_we;
        bus.csr_data_i       = ex.csr;
        bus.stall_i          = st;
        bus.flush_i          = fl;
        rst                  = r;
        @(posedge clk);
        model_edge(ex, st, fl, r, bus.dmem_dout_i);
        #1;
        bus.dmem_dout_i = dout_after;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            step(rand_ex(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b1, $urandom);
        checks++; if (bus.wb_data_o !== 32'd0)
            $display("FAIL reset_wb_data: got %h want 00000000", bus.wb_data_o); else passed++;
        checks++; if (bus.wb_addr_o !== 5'd0)
            $display("FAIL reset_wb_addr: got %h want 00", bus.wb_addr_o); else passed++;
        checks++; if (bus.is_wb_o !== 1'b0)
            $display("FAIL reset_is_wb: got %b want 0", bus.is_wb_o); else passed++;
        checks++; if (bus.csr_tohost_o !== 32'd0)
            $display("FAIL reset_tohost: got %h want 00000000", bus.csr_tohost_o); else passed++;
        checks++; if (bus.instret_o !== 32'd0)
            $display("FAIL reset_instret: got %h want 00000000", bus.instret_o); else passed++;
    endtask

    task automatic test_load_extract();
        step(mk_ex(1, 32'h1001, 0, 5'd5, 1, 2'b01, 3'b000, 0, 0), 0, 0, 0, 32'h0000_8000);
        checks++; if (bus.wb_data_o !== 32'hFFFF_FF80)
            $display("FAIL lb_sext: got %h want ffffff80", bus.wb_data_o); else passed++;
        checks++; if (bus.is_wb_o !== 1'b1 || bus.wb_addr_o !== 5'd5)
            $display("FAIL lb_wb_en: got %b/%0d want 1/5", bus.is_wb_o, bus.wb_addr_o); else passed++;
        step(mk_ex(1, 32'h1001, 0, 5'd6, 1, 2'b01, 3'b100, 0, 0), 0, 0, 0, 32'h0000_8000);
        checks++; if (bus.wb_data_o !== 32'h0000_0080)
            $display("FAIL lbu_zext: got %h want 00000080", bus.wb_data_o); else passed++;
        step(mk_ex(1, 32'h1002, 0, 5'd7, 1, 2'b01, 3'b101, 0, 0), 0, 0, 0, 32'hBEEF_0000);
        checks++; if (bus.wb_data_o !== 32'h0000_BEEF)
            $display("FAIL lhu_upper: got %h want 0000beef", bus.wb_data_o); else passed++;
        step(mk_ex(1, 32'h1002, 0, 5'd7, 1, 2'b01, 3'b001, 0, 0), 0, 0, 0, 32'hBEEF_0000);
        checks++; if (bus.wb_data_o !== 32'hFFFF_BEEF)
            $display("FAIL lh_sext: got %h want ffffbeef", bus.wb_data_o); else passed++;
    endtask

    task automatic test_load_stall();
        logic [31:0] base;
        step(mk_ex(1, 32'h3000, 0, 5'd9, 1, 2'b01, 3'b010, 0, 0), 0, 0, 0, 32'h1234_5678);
        base = m_instret;
        checks++; if (bus.wb_data_o !== 32'h1234_5678)
            $display("FAIL lw_live: got %h want 12345678", bus.wb_data_o); else passed++;
        for (int i = 0; i < 3; i++) begin
            step(rand_ex(), 1, 0, 0, $urandom);
            checks++; if (bus.wb_data_o !== 32'h1234_5678)
                $display("FAIL lw_held%0d: got %h want 12345678", i, bus.wb_data_o); else passed++;
            checks++; if (bus.instret_o !== base)
                $display("FAIL lw_stall_instret%0d: got %h want %h", i, bus.instret_o, base); else passed++;
        end
        step('0, 0, 0, 0, $urandom);
        checks++; if (bus.instret_o !== base + 32'd1)
            $display("FAIL lw_release_instret: got %h want %h", bus.instret_o, base + 32'd1); else passed++;
    endtask

    task automatic test_flush_priority();
        logic [31:0] base;
        step(mk_ex(1, 32'h4000, 0, 5'd3, 1, 2'b01, 3'b010, 0, 0), 0, 0, 0, 32'hAAAA_5555);
        step(rand_ex(), 1, 0, 0, 32'h1111_1111);
        checks++; if (bus.wb_data_o !== 32'hAAAA_5555)
            $display("FAIL pre_flush_held: got %h want aaaa5555", bus.wb_data_o); else passed++;
        base = m_instret;
        step(mk_ex(1, $urandom, $urandom, 5'd4, 1, 2'b00, 3'b000, 1, $urandom), 1, 1, 0, $urandom);
        checks++; if (bus.is_wb_o !== 1'b0)
            $display("FAIL flush_is_wb: got %b want 0", bus.is_wb_o); else passed++;
        checks++; if (bus.instret_o !== base)
            $display("FAIL flush_instret: got %h want %h", bus.instret_o, base); else passed++;
        // the next load must see DMEM live again, not the old held word
        step(mk_ex(1, 32'h2000, 0, 5'd8, 1, 2'b01, 3'b010, 0, 0), 0, 0, 0, 32'h0BAD_F00D);
        checks++; if (bus.wb_data_o !== 32'h0BAD_F00D)
            $display("FAIL post_flush_live: got %h want 0badf00d", bus.wb_data_o); else passed++;
    endtask

    task automatic test_x0_sources();
        step(mk_ex(1, 32'h55, 0, 5'd0, 1, 2'b00, 3'b000, 0, 0), 0, 0, 0, $urandom);
        checks++; if (bus.is_wb_o !== 1'b0)
            $display("FAIL x0_is_wb: got %b want 0", bus.is_wb_o); else passed++;
        step(mk_ex(1, 32'h77, 32'h2004, 5'd1, 1, 2'b10, 3'b000, 0, 0), 0, 0, 0, $urandom);
        checks++; if (bus.wb_data_o !== 32'h0000_2004)
            $display("FAIL jal_pc4: got %h want 00002004", bus.wb_data_o); else passed++;
        checks++; if (bus.is_wb_o !== 1'b1)
            $display("FAIL jal_is_wb: got %b want 1", bus.is_wb_o); else passed++;
        step(mk_ex(1, 32'h99, 0, 5'd2, 1, 2'b00, 3'b000, 0, 0), 0, 0, 0, $urandom);
        checks++; if (bus.wb_data_o !== 32'h0000_0099)
            $display("FAIL alu_src: got %h want 00000099", bus.wb_data_o); else passed++;
    endtask

    task automatic test_csr_wrap();
        step(mk_ex(1, 0, 0, 5'd7, 1, 2'b11, 3'b000, 1, 32'hCAFE_F00D), 0, 0, 0, $urandom);
        checks++; if (bus.wb_data_o !== 32'hCAFE_F00D)
            $display("FAIL csr_read: got %h want cafef00d", bus.wb_data_o); else passed++;
        step('0, 0, 0, 0, $urandom);
        checks++; if (bus.csr_tohost_o !== 32'hCAFE_F00D)
            $display("FAIL csr_tohost: got %h want cafef00d", bus.csr_tohost_o); else passed++;
        step(mk_ex(1, 0, 0, 5'd7, 1, 2'b11, 3'b000, 1, 32'h0001_2345), 0, 0, 0, $urandom);
        step('0, 1, 0, 0, $urandom);
        step('0, 0, 1, 0, $urandom);
        checks++; if (bus.csr_tohost_o !== 32'hCAFE_F00D)
            $display("FAIL csr_no_write_bubble: got %h want cafef00d", bus.csr_tohost_o); else passed++;
        // preload the counter just below the wrap point
        force dut.instret = 32'hFFFF_FFFE;
        #1;
        release dut.instret;
        m_instret = 32'hFFFF_FFFE;
        step(mk_ex(1, 0, 0, 5'd1, 1, 2'b00, 3'b000, 0, 0), 0, 0, 0, $urandom);
        step(mk_ex(1, 0, 0, 5'd1, 1, 2'b00, 3'b000, 0, 0), 0, 0, 0, $urandom);
        checks++; if (bus.instret_o !== 32'hFFFF_FFFF)
            $display("FAIL instret_max: got %h want ffffffff", bus.instret_o); else passed++;
        step('0, 0, 0, 0, $urandom);
        checks++; if (bus.instret_o !== 32'h0000_0000)
            $display("FAIL instret_wrap: got %h want 00000000", bus.instret_o); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        step(mk_ex(1, 32'h5000, 0, 5'd12, 1, 2'b01, 3'b010, 0, 0), 0, 0, 0, 32'hDEAD_BEEF);
        step(rand_ex(), 1, 0, 0, $urandom);
        step(rand_ex(), 1, 0, 1, 32'h0000_0000);
        checks++; if (bus.wb_data_o !== 32'd0 || bus.is_wb_o !== 1'b0 || bus.instret_o !== 32'd0)
            $display("FAIL rst_mid_stall: got %h/%b/%h want 00000000/0/00000000",
                     bus.wb_data_o, bus.is_wb_o, bus.instret_o); else passed++;
        step(mk_ex(1, 32'h5000, 0, 5'd12, 1, 2'b01, 3'b010, 0, 0), 0, 0, 0, 32'h600D_CAFE);
        checks++; if (bus.wb_data_o !== 32'h600D_CAFE)
            $display("FAIL rst_then_live: got %h want 600dcafe", bus.wb_data_o); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(rand_ex(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 1'b0, $urandom);
            checks++; if (bus.is_wb_o !== exp_is_wb())
                $display("FAIL rnd_is_wb[%0d]: got %b want %b", i, bus.is_wb_o, exp_is_wb()); else passed++;
            if (m_valid) begin
                checks++; if (bus.wb_data_o !== exp_wb_data())
                    $display("FAIL rnd_wb_data[%0d]: got %h want %h", i, bus.wb_data_o, exp_wb_data()); else passed++;
                checks++; if (bus.wb_addr_o !== m_ex.rd)
                    $display("FAIL rnd_wb_addr[%0d]: got %0d want %0d", i, bus.wb_addr_o, m_ex.rd); else passed++;
            end
            checks++; if (bus.instret_o !== m_instret)
                $display("FAIL rnd_instret[%0d]: got %h want %h", i, bus.instret_o, m_instret); else passed++;
            checks++; if (bus.csr_tohost_o !== m_tohost)
                $display("FAIL rnd_tohost[%0d]: got %h want %h", i, bus.csr_tohost_o, m_tohost); else passed++;
        end
    endtask

    initial begin
        bus.dmem_dout_i = '0;
        test_reset();
        test_load_extract();
        test_load_stall();
        test_flush_priority();
        test_x0_sources();
        test_csr_wrap();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ex_wb.md
EX_WB -- requirements
Module: ex_wb

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset; one clock; synchronous, active-high.
REQ-003 SHALL: stall_i  input  1  hold the stage contents this cycle.
REQ-004 SHALL: flush_i  input  1  load a bubble on the next edge; wins over stall_i.
REQ-005 SHALL: valid_i  input  1  EX holds a real instruction.
REQ-006 SHALL: alu_result_i  input  32  EX result; also the load address.
REQ-007 SHALL: pc_plus_i  input  32  pc+4 of the EX instruction.
REQ-008 SHALL: rd_addr_i  input  5  destination register.
REQ-009 SHALL: control_wb_i  input  1  instruction writes rd.
REQ-010 SHALL: control_wr_mux_i  input  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 CSR read data.
REQ-011 SHALL: control_load_i  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 SHALL: control_csr_we_i  input  1  CSR write.
REQ-013 SHALL: csr_data_i  input  32  CSR write/read data.
REQ-014 SHALL: dmem_dout_i  input  32  synchronous DMEM read word, valid the cycle after the address.
REQ-015 SHALL: wb_data_o  output  32  writeback data (combinational from stage state); feeds the regfile and the ID bypass.
REQ-016 SHALL: wb_addr_o  output  5  writeback register address.
REQ-017 SHALL: is_wb_o  output  1  writeback enable.
REQ-018 SHALL: csr_tohost_o  output  32  tohost CSR value.
REQ-019 SHALL: instret_o  output  32  count of retired instructions.

Function
REQ-020 SHALL: stage register: on each edge with no stall and no flush, capture valid_i, alu_result_i, pc_plus_i, rd_addr_i, control_*_i and csr_data_i.
REQ-021 SHALL: retained byte offset = captured alu_result_i[1:0].
REQ-022 SHALL: flush_i=1 clears the valid bit on the next edge; other fields are don't-care.
REQ-023 SHALL: stall_i=1 with flush_i=0 holds every stage field unchanged.
REQ-024 SHALL: is_wb_o = valid & control_wb & (rd != 0); wb_addr_o = stored rd.
REQ-025 SHALL: wb_data_o selects by wr_mux: ALU result, extracted load data, pc+4, or csr_data.
REQ-026 SHALL: load extraction uses word W (see REQ-031).
- LB/LBU: byte W[8*off+7 : 8*off], sign- or zero-extended.
- LH/LHU: half selected by off[1], sign- or zero-extended.
- LW and undefined funct3: W unchanged.
REQ-027 SHALL: wb_data_o is valid in the same cycle the load occupies the stage; total load latency = 1 cycle after EX.
REQ-028 SHALL: load-hold FSM, states LIVE and HELD.
- LIVE: W = dmem_dout_i.
- HELD: W = hold register.
REQ-029 SHALL: LIVE -> HELD when stall_i=1 and flush_i=0 and the stage is valid with wr_mux=01; the same edge latches dmem_dout_i into the hold register.
REQ-030 SHALL: HELD -> LIVE on any edge with stall_i=0 or flush_i=1; the hold register is unchanged while HELD.
REQ-031 SHALL: in HELD, W is the hold register, independent of later dmem_dout_i changes.
REQ-032 SHALL: retire event = valid & !stall_i & !flush_i at an edge.
REQ-033 SHALL: on a retire event with control_csr_we, csr_tohost_o <= csr_data on that edge.
REQ-034 SHALL: instret_o increments by 1 per retire event and wraps 0xFFFFFFFF -> 0.
REQ-035 SHALL: stalled or bubbled cycles never count and never write CSR.
REQ-036 SHALL: simultaneous stall_i and flush_i behave as flush_i alone.

Reset
REQ-037 SHALL: rst=1 at an edge clears valid, all stage fields, csr_tohost_o and instret_o to 0, and sets the FSM to LIVE.
REQ-038 SHALL: after reset, wb_data_o = 0, wb_addr_o = 0, is_wb_o = 0.
REQ-039 SHALL: rst overrides stall_i and flush_i; asserting reset mid-stall discards the held load.

Verification
REQ-040 SHALL: reset -> rst high 2 cycles with random inputs -> all outputs 0; FSM in LIVE.
REQ-041 SHALL: LB sign extension -> LB, addr 0x1001, dout 0x0000_8000 -> wb_data_o 0xFFFFFF80.
- LBU with the same addr/dout -> 0x00000080.
- LHU, addr 0x1002, dout 0xBEEF_0000 -> 0x0000BEEF.
REQ-042 SHALL: load under stall -> LW stalled 3 cycles, dout 0x12345678 then changing to garbage.
- wb_data_o stays 0x12345678 throughout.
- Exactly 1 instret increment on release.
REQ-043 SHALL: flush priority -> stall_i=flush_i=1 with valid_i=1 -> next cycle is_wb_o=0, instret_o unchanged, FSM in LIVE.
REQ-044 SHALL: x0 and sources -> rd=0 with control_wb=1 -> is_wb_o=0.
- JAL with wr_mux=10, pc_plus 0x2004 -> wb_data_o 0x2004.
REQ-045 SHALL: CSR and counter wrap -> CSR write 0xCAFEF00D retires -> csr_tohost_o = 0xCAFEF00D.
- instret preloaded via retires to 0xFFFFFFFF, one more retire -> 0x00000000.
